// File: rtl/ling_hc_pipe_adder.sv
// ling_hc_pipe_adder: pipelined Ling/Han-Carlson prefix adder with valid/ready handshake and multi-beat carry chaining
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid / in_ready       operand beat handshake
//   in_a, in_b [WIDTH]        operands
//   in_cin                    carry-in when in_chain=0
//   in_chain                  1: carry-in is out_cout of the previous output beat
//   out_valid / out_ready     result handshake
//   out_sum [WIDTH]           (A + B + cin) mod 2^WIDTH
//   out_cout                  carry out of the MSB
//   out_ovf                   two's complement overflow of this beat
module ling_hc_pipe_adder #(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_chain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int LEVELS = $clog2(WIDTH) + 1;
   localparam int NSEG = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam logic [WIDTH-1:0] ODD = {(WIDTH/2){2'b10}};

   // x: half sum, p: per-bit propagate, h/t: Ling pseudo-carry and transmit group terms
   typedef struct packed {
      logic [WIDTH-1:0] x, p, h, t;
      logic cin, chain, am, bm;
   } beat_t;

   // Runs REG_EVERY prefix levels starting at level lo. Levels below LEVELS-1 are the
   // sparse odd-bit tree (span doubles each level); the last level fixes up even bits.
   function automatic beat_t seg(input beat_t s, input int lo);
      beat_t r;
      logic [WIDTH-1:0] h, t, m;
      int d;
      r = s;
      for (int l = lo; l < lo + REG_EVERY && l < LEVELS; l++) begin
         h = r.h;
         t = r.t;
         d = (l < LEVELS - 1) ? (1 << l) : 1;
         m = ((l < LEVELS - 1) ? ODD : ~ODD) & ({WIDTH{1'b1}} << d);
         r.h = h | (t & (h << d) & m);
         r.t = t & (~m | (t << d));
      end
      return r;
   endfunction

   logic [NSEG:0]    vld;
   logic [WIDTH-1:0] a0, b0;
   logic             cin0, chain0, creg, adv, cin_eff;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;
   beat_t            pre;
   beat_t            st  [1:NSEG];
   beat_t            nxt [1:NSEG];

   assign adv = !out_valid | out_ready;
   assign in_ready = adv;
   assign out_valid = vld[NSEG];

   // t_i = p_{i-1}; bit 0 transmits unconditionally so the group transmit
   // covers the whole run of propagates below each bit for the late carry-in
   always_comb begin
      pre.x = a0 ^ b0;
      pre.p = a0 | b0;
      pre.h = a0 & b0;
      pre.t = {pre.p[WIDTH-2:0], 1'b1};
      pre.cin = cin0;
      pre.chain = chain0;
      pre.am = a0[WIDTH-1];
      pre.bm = b0[WIDTH-1];
   end

   for (genvar k = 1; k <= NSEG; k++) begin : g_seg
      if (k == 1) begin : g_first
         assign nxt[k] = seg(pre, 0);
      end else begin : g_rest
         assign nxt[k] = seg(st[k-1], (k - 1) * REG_EVERY);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         creg <= 1'b0;
      end else begin
         if (out_valid && out_ready) creg <= out_cout;
         if (adv) begin
            vld <= {vld[NSEG-1:0], in_valid};
            a0 <= in_a;
            b0 <= in_b;
            cin0 <= in_cin;
            chain0 <= in_chain;
            for (int k = 1; k <= NSEG; k++) st[k] <= nxt[k];
         end
      end
   end

   // Ling resolve: c_{i+1} = p_i & (H_i | T_i & cin)
   always_comb begin
      cin_eff = st[NSEG].chain ? creg : st[NSEG].cin;
      c = {st[NSEG].p & (st[NSEG].h | (st[NSEG].t & {WIDTH{cin_eff}})), cin_eff};
      sum = st[NSEG].x ^ c[WIDTH-1:0];
      out_sum = out_valid ? sum : '0;
      out_cout = out_valid & c[WIDTH];
      out_ovf = out_valid & (st[NSEG].am ~^ st[NSEG].bm) & (sum[WIDTH-1] ^ st[NSEG].am);
   end
endmodule

// File: tb/tb_ling_hc_pipe_adder.sv
// tb_ling_hc_pipe_adder: scoreboard bench for ling_hc_pipe_adder against an arithmetic model
module tb_ling_hc_pipe_adder;
   localparam int W = 32;
   localparam int RE = 2;

   typedef struct packed {
      logic [W-1:0] sum;
      logic cout, ovf;
   } exp_t;

   logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, in_chain = 0, out_ready = 1;
   logic in_ready, out_valid, out_cout, out_ovf;
   logic [W-1:0] in_a = '0, in_b = '0, out_sum;
   exp_t q[$];
   logic mcarry = 0;
   bit rnd_rdy = 0;
   int n_chk = 0, n_fail = 0;

   ling_hc_pipe_adder #(.WIDTH(W), .REG_EVERY(RE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_chain(in_chain),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Reference: plain wide addition; chained beats take the carry of the previous beat in issue order
   task automatic push_model(input logic [W-1:0] a, b, input logic cin, chain);
      logic [W:0] full;
      logic ci;
      longint s, lim;
      ci = chain ? mcarry : cin;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      lim = 64'sd1 <<< (W - 1);
      q.push_back('{full[W-1:0], full[W], (s >= lim) || (s < -lim)});
      mcarry = full[W];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, b, input logic cin, chain,
                        input bit has_exp = 0, input exp_t e = '0);
      bit done = 0;
      in_valid = 1; in_a = a; in_b = b; in_cin = cin; in_chain = chain;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            if (has_exp) begin
               q.push_back(e);
               mcarry = e.cout;
            end else push_model(a, b, cin, chain);
            done = 1;
         end
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
      end
      in_valid = 0;
      if (!done) bound_fail("accept");
   endtask

   function automatic logic [W-1:0] rv();
      int s;
      s = $urandom_range(7);
      return s == 0 ? '0 : s == 1 ? '1 : s == 2 ? 32'h7FFF_FFFF : s == 3 ? 32'h8000_0000 : W'($urandom);
   endfunction

   // Monitor: pops and compares every output transfer; checks outputs hold while stalled
   bit stall_p = 0;
   logic [W+2:0] held;
   exp_t got;
   always @(negedge clk) begin
      if (rst) stall_p = 0;
      else begin
         if (stall_p) chk("stall_hold", {out_valid, out_sum, out_cout, out_ovf}, held);
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got sum %0h with empty scoreboard", out_sum);
            end else begin
               got = q.pop_front();
               chk("sum", out_sum, got.sum);
               chk("cout", out_cout, got.cout);
               chk("ovf", out_ovf, got.ovf);
            end
         end
         stall_p = out_valid && !out_ready;
         held = {out_valid, out_sum, out_cout, out_ovf};
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout", out_cout, 0);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);

      // max + 1 wraps, output appears in the 4th cycle after the accept cycle
      issue(32'hFFFF_FFFF, 32'h1, 0, 0, 1, '{32'h0, 1'b1, 1'b0});
      repeat (2) begin
         @(posedge clk); #1;
         chk("lat_early", out_valid, 0);
      end
      @(posedge clk); #1;
      chk("lat_4", out_valid, 1);
      idle(3);

      // 96-bit add over three chained beats
      issue(32'hFFFF_FFFF, 32'h1, 0, 0, 1, '{32'h0, 1'b1, 1'b0});
      issue(32'h0, 32'h0, 0, 1, 1, '{32'h1, 1'b0, 1'b0});
      issue(32'h7FFF_FFFF, 32'h0, 0, 1, 1, '{32'h7FFF_FFFF, 1'b0, 1'b0});
      idle(6);

      // signed overflow corners
      issue(32'h7FFF_FFFF, 32'h1, 0, 0, 1, '{32'h8000_0000, 1'b0, 1'b1});
      issue(32'h8000_0000, 32'h8000_0000, 0, 0, 1, '{32'h0, 1'b1, 1'b1});
      idle(6);

      // fill pipe then stall 5 cycles with a beat waiting
      for (int i = 0; i < 4; i++) issue(rv(), rv(), 1'($urandom), 1'($urandom));
      out_ready = 0;
      in_valid = 1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_cin = 1; in_chain = 0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1;
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
      idle(6);

      // reset mid-stream: creg left at 1, then cleared by reset
      issue(32'hFFFF_FFFF, 32'h1, 0, 0);
      idle(6);
      for (int i = 0; i < 3; i++) issue(rv(), rv(), 1'($urandom), 0);
      rst = 1;
      q.delete();
      mcarry = 0;
      @(posedge clk); #1;
      rst = 0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", out_sum, 0);
      chk("mid_rst_cout", out_cout, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      issue(32'h1, 32'h1, 0, 1, 1, '{32'h2, 1'b0, 1'b0});
      idle(6);

      // random traffic with bubbles, backpressure and chaining
      rnd_rdy = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
         issue(rv(), rv(), 1'($urandom), 1'($urandom));
      end
      rnd_rdy = 0;
      out_ready = 1;
      for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
      #1;
      if (q.size() != 0) bound_fail("drain");
      idle(5);
      chk("scoreboard_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
